fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the 16-bit multi-cycle CPU, directly upstream of `register_file`. Holds the PC and runs a read handshake with instruction memory. Latches the returned word into an instruction register, then presents decoded fields to the datapath. The rs/rt/rd fields drive `register_file` `read1`/`read2`/`write_reg` without further logic.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, fetch address loaded on reset.
- Word width is `` `WORD_SIZE `` (16) from `opcodes.v`. It is not a module parameter.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `readM`  out  1  instruction-memory read request.
- `address`  out  16  fetch address, valid while `readM`=1.
- `data`  in  16  memory read data, sampled when `inputReady`=1.
- `inputReady`  in  1  memory data-valid; single-cycle pulse, legal only while `readM`=1.
- `instr_valid`  out  1  instruction register holds an unconsumed instruction.
- `instr_ack`  in  1  downstream consumes the instruction; meaningful only when `instr_valid`=1.
- `redirect`  in  1  PC override from branch/jump resolution.
- `redirect_pc`  in  16  new fetch address, sampled when `redirect`=1.
- `instr`  out  16  raw instruction register.
- `opcode`  out  4  `instr[15:12]`.
- `rs`  out  2  `instr[11:10]`, to `register_file.read1`.
- `rt`  out  2  `instr[9:8]`, to `register_file.read2`.
- `rd`  out  2  `instr[7:6]`, to `register_file.write_reg`.
- `func`  out  6  `instr[5:0]`.
- `imm`  out  16  `{{8{instr[7]}}, instr[7:0]}`, sign-extended.
- `target`  out  12  `instr[11:0]`.
- `pc`  out  16  address of the instruction in `instr`.
- `num_inst`  out  16  count of acknowledged instructions.

## Operation
States:
- **IDLE**: `readM`=0. Next state is FETCH unless `redirect`=1.
- **FETCH**: `readM`=1, `address`=`fetch_pc`.
  - `inputReady`=1: `instr`<=`data`, `pc`<=`fetch_pc`, go to HOLD.
- **HOLD**: `instr_valid`=1, `readM`=0.
  - `instr_ack`=1: `fetch_pc`<=`pc`+1 (16-bit wrap, FFFF->0000), `num_inst`+=1 (wraps), go to FETCH.

Redirect rules (`redirect`=1 in any state):
- Updates: `fetch_pc`<=`redirect_pc`, next state IDLE.
- Redirect has priority over `inputReady` and `instr_ack`. Data returned in the same cycle is discarded, and an ack in the same cycle does not increment `num_inst`.
- The instruction register is not overwritten. `instr_valid` drops because the state leaves HOLD.

Other boundary cases:
- `inputReady` outside FETCH is ignored.
- `instr_ack` outside HOLD is ignored.
- Reset dominates everything, including during an outstanding read.
  - `readM` drops the next cycle.
  - Any late `inputReady` is ignored because the state is IDLE.

Reset values:
- state IDLE, `fetch_pc`=`RESET_PC`, `pc`=0, `instr`=0, `num_inst`=0.
- Therefore `readM`=0, `instr_valid`=0, and all decoded fields are 0.

## Timing
- Cycle 0 is the first posedge with `reset`=0. State goes IDLE→FETCH, so `readM`=1 during cycle 1.
- Decoded fields:
  - Combinational from `instr`.
  - Valid in the cycle after the `inputReady` edge.
  - Stable for every cycle `instr_valid`=1.
- Fetch latency is 1 cycle from `inputReady` to `instr_valid`.
- Best-case throughput is 1 instruction per 2 cycles (FETCH, HOLD).
- Redirect penalty is 1 IDLE cycle before the new `readM`.
- Outputs are registered or decoded from registers only. There is no combinational path from `data` to any output.

## Structure
- `opcodes.v` gains field-position macros (`OPCODE_HI`/`LO`, `RS_HI`/`LO`, etc.) and `` `RESET_PC_DEFAULT ``.
- State encodings are local parameters inside the module; they are not shared.
- One sub-module: `instr_decode`, purely combinational. It maps `instr` to `opcode`/`rs`/`rt`/`rd`/`func`/`imm`/`target` and is reusable by the later decode/control stage.

## Test plan
- **Reset and first fetch.** Hold `reset` for 3 cycles, then release. Required: `readM`=0 and all outputs 0 during reset; `readM`=1 with `address`=0000 one cycle after release.
- **Basic fetch and decode.** In FETCH, pulse `inputReady` with `data`=16'h4A85. Next cycle required: `instr_valid`=1, `opcode`=4, `rs`=2, `rt`=2, `rd`=2, `func`=6'h05, `imm`=16'hFF85, `target`=12'hA85, `pc`=0000.
- **Acknowledge and advance.** Ack the valid instruction at `pc`=0007. Required: next cycle `readM`=1 with `address`=0008, and `num_inst` incremented. Acking at `pc`=FFFF fetches 0000.
- **Redirect races.** `redirect`=1 with `redirect_pc`=0040 in the same cycle as `inputReady`. Required: data discarded, one cycle of `readM`=0, then `address`=0040. Separately, `redirect` together with `instr_ack` in HOLD must leave `num_inst` unchanged.
- **Reset mid-read.** Assert `reset` while in FETCH with no `inputReady` yet, then pulse `inputReady` during reset. Required: `instr_valid` stays 0, `instr`=0, and the post-reset fetch goes to `RESET_PC`.
- **Stall hold.** Keep `instr_ack`=0 for 10 cycles in HOLD while toggling `data` and `inputReady`. Required: `instr`, fields and `pc` unchanged, and `readM`=0 throughout.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared word width, instruction field positions and reset PC
package fetch_unit_pkg;

  localparam int WORD_SIZE = 16;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int RS_HI     = 11;
  localparam int RS_LO     = 10;
  localparam int RT_HI     = 9;
  localparam int RT_LO     = 8;
  localparam int RD_HI     = 7;
  localparam int RD_LO     = 6;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 11;
  localparam int TARGET_LO = 0;

  localparam logic [WORD_SIZE-1:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_unit_instr_decode.sv
// rtl/fetch_unit_instr_decode.sv - combinational instruction field decode
module instr_decode
  import fetch_unit_pkg::*;
(
  input  logic [WORD_SIZE-1:0] instr,
  output logic [3:0]           opcode,
  output logic [1:0]           rs,
  output logic [1:0]           rt,
  output logic [1:0]           rd,
  output logic [5:0]           func,
  output logic [WORD_SIZE-1:0] imm,
  output logic [11:0]          target
);

  assign opcode = instr[OPCODE_HI:OPCODE_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign func   = instr[FUNC_HI:FUNC_LO];
  // 8-bit immediate, sign-extended to a full word
  assign imm    = {{(WORD_SIZE-8){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
  assign target = instr[TARGET_HI:TARGET_LO];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, instruction-memory read handshake and instruction register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        readM,
  output logic [15:0] address,
  input  logic [15:0] data,
  input  logic        inputReady,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [1:0]  rs,
  output logic [1:0]  rt,
  output logic [1:0]  rd,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [11:0] target,
  output logic [15:0] pc,
  output logic [15:0] num_inst
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Redirect overrides any handshake completing in the same cycle
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = FETCH;
        FETCH:   if (inputReady) state_next = HOLD;
        HOLD:    if (instr_ack)  state_next = FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pc       <= 16'h0000;
      instr    <= 16'h0000;
      num_inst <= 16'h0000;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
    end else if (state == FETCH && inputReady) begin
      instr <= data;
      pc    <= fetch_pc;
    end else if (state == HOLD && instr_ack) begin
      fetch_pc <= pc + 16'd1;
      num_inst <= num_inst + 16'd1;
    end
  end

  assign readM       = (state == FETCH);
  assign address     = fetch_pc;
  assign instr_valid = (state == HOLD);

  instr_decode u_decode (
    .instr  (instr),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .func   (func),
    .imm    (imm),
    .target (target)
  );

endmodule
